// File: rtl/write_flush_ctrl_pkg.sv
// Shared types for the Write-stage flush/redirect sequencer: FSM state
// encoding, default exception vector, and the Moore output bundle with the
// helper that decodes it from the current state.
package write_flush_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        FLUSH = 3'd2,
        REDIR = 3'd3,
        HAZ   = 3'd4
    } flush_state_e;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    // flush is a single "kill every lane" flag; the top widens it to STAGES bits.
    typedef struct packed {
        logic        flush;
        logic        fetch_stall;
        logic        redirect_valid;
        logic [31:0] redirect_pc;
    } flush_ctrl_t;

    // Outputs depend only on the state (and the target latched on entry), so
    // they are glitch-free registered decodes rather than input-driven paths.
    function automatic flush_ctrl_t decode_ctrl(input flush_state_e st,
                                                input logic [31:0]  target);
        flush_ctrl_t c;
        c = '0;
        case (st)
            WAIT, FLUSH: begin
                c.flush       = 1'b1;
                c.fetch_stall = 1'b1;
            end
            REDIR: begin
                c.redirect_valid = 1'b1;
                c.redirect_pc    = target;
            end
            HAZ: begin
                c.fetch_stall = 1'b1;
            end
            default: begin
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/write_flush_ctrl_if.sv
// Write-stage to flush-sequencer bundle. master = the side that produces the
// Write-stage flags and consumes flush/redirect; slave = the sequencer.
interface write_flush_ctrl_if #(
    parameter int STAGES = 5
);
    logic              exception_valid;
    logic              eret_exist;
    logic              mtc0_exist;
    logic              jmp_valid;
    logic [31:0]       jmp_pc;
    logic              mem_busy;
    logic [STAGES-1:0] flush;
    logic              fetch_stall;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              ctrl_busy;

    modport master (
        output exception_valid, eret_exist, mtc0_exist, jmp_valid, jmp_pc, mem_busy,
        input  flush, fetch_stall, redirect_valid, redirect_pc, ctrl_busy
    );

    modport slave (
        input  exception_valid, eret_exist, mtc0_exist, jmp_valid, jmp_pc, mem_busy,
        output flush, fetch_stall, redirect_valid, redirect_pc, ctrl_busy
    );
endinterface

// File: rtl/write_flush_ctrl_down_counter.sv
// Small load/decrement counter shared by the FLUSH and MTC0-hazard phases.
// Load wins over decrement; decrement saturates at zero so it never wraps.
module flush_down_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: reload, count down toward zero, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register, cleared by the async reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/write_flush_ctrl.sv
// Flush/redirect sequencer driven by the Write stage. On an exception, ERET or
// forwarded jump it waits for the in-flight bus request to drain, flushes all
// lanes for FLUSH_CYCLES, then pulses a one-cycle PC redirect. An MTC0 commit
// alone only stalls Fetch for MTC0_HAZ cycles.
// Optional build macro: WRITE_FLUSH_PERF_EN adds perf_redir_cnt/perf_stall_cnt.
module write_flush_ctrl
    import write_flush_ctrl_pkg::*;
#(
    parameter int          STAGES       = 5,
    parameter int          FLUSH_CYCLES = 2,
    parameter int          MTC0_HAZ     = 3,
    parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
    input  logic                clk,
    input  logic                resetn,
    write_flush_ctrl_if.slave   bus
`ifdef WRITE_FLUSH_PERF_EN
    ,
    output logic [31:0]         perf_redir_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    localparam int CNT_MAX = (FLUSH_CYCLES > MTC0_HAZ) ? FLUSH_CYCLES : MTC0_HAZ;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HAZ_LOAD   = CNT_W'(MTC0_HAZ - 1);

    flush_state_e     state_q;
    flush_state_e     state_d;
    logic [31:0]      target_q;
    logic [31:0]      target_d;
    logic             redir_evt;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;
    flush_ctrl_t      ctrl;

    assign redir_evt = bus.exception_valid | bus.eret_exist | bus.jmp_valid;

    flush_down_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Next-state, target capture and counter control. Events are only
    // honoured in IDLE and HAZ; a redirect event always beats MTC0.
    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        cnt_load     = 1'b0;
        cnt_load_val = FLUSH_LOAD;
        cnt_dec      = 1'b0;
        case (state_q)
            IDLE, HAZ: begin
                if (redir_evt) begin
                    target_d = bus.jmp_valid ? bus.jmp_pc : EXC_VECTOR;
                    if (bus.mem_busy) begin
                        state_d = WAIT;
                    end else begin
                        state_d  = FLUSH;
                        cnt_load = 1'b1;
                    end
                end else if (state_q == IDLE) begin
                    if (bus.mtc0_exist) begin
                        state_d      = HAZ;
                        cnt_load     = 1'b1;
                        cnt_load_val = HAZ_LOAD;
                    end
                end else if (cnt_zero) begin
                    state_d = IDLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WAIT: begin
                // The outstanding bus request cannot be cancelled; hold here.
                if (!bus.mem_busy) begin
                    state_d  = FLUSH;
                    cnt_load = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt_zero) begin
                    state_d = REDIR;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            REDIR: begin
                // Always leave after one cycle so redirect_valid never repeats.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched redirect target; reset aborts any sequence at once.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    // Moore output decode from the registered state.
    always_comb begin
        ctrl = decode_ctrl(state_q, target_q);
    end

    assign bus.flush          = {STAGES{ctrl.flush}};
    assign bus.fetch_stall    = ctrl.fetch_stall;
    assign bus.redirect_valid = ctrl.redirect_valid;
    assign bus.redirect_pc    = ctrl.redirect_pc;
    assign bus.ctrl_busy      = (state_q != IDLE);

`ifdef WRITE_FLUSH_PERF_EN
    logic [31:0] perf_redir_q;
    logic [31:0] perf_stall_q;

    // Free-running event counters; wrap naturally at 2^32.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_redir_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (state_q == REDIR) begin
                perf_redir_q <= perf_redir_q + 32'd1;
            end
            if (ctrl.fetch_stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_redir_cnt = perf_redir_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_write_flush_ctrl.sv
// Testbench for write_flush_ctrl. Stimulus is issued as whole transactions
// (redirect with N bus-busy cycles, MTC0 hazard, MTC0 pre-empted by a
// redirect); each transaction pushes the per-cycle outputs it implies into a
// scoreboard queue that a separate monitor pops at every falling edge.
module tb_write_flush_ctrl;

    localparam int          STAGES       = 5;
    localparam int          FLUSH_CYCLES = 2;
    localparam int          MTC0_HAZ     = 3;
    localparam logic [31:0] EXC_VEC      = 32'hBFC0_0380;
    localparam logic [31:0] JUNK_PC      = 32'h0000_1234;

    typedef struct packed {
        logic [STAGES-1:0] flush;
        logic              stall;
        logic              rv;
        logic [31:0]       rpc;
        logic              busy;
    } exp_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    write_flush_ctrl_if #(.STAGES(STAGES)) bus ();

`ifdef WRITE_FLUSH_PERF_EN
    logic [31:0] perf_redir_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    write_flush_ctrl #(
        .STAGES       (STAGES),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .MTC0_HAZ     (MTC0_HAZ),
        .EXC_VECTOR   (EXC_VEC)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
`ifdef WRITE_FLUSH_PERF_EN
        ,
        .perf_redir_cnt (perf_redir_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    function automatic exp_t e_idle();
        exp_t e;
        e = '0;
        return e;
    endfunction

    function automatic exp_t e_flush();
        exp_t e;
        e = '0;
        e.flush = '1;
        e.stall = 1'b1;
        e.busy  = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_haz();
        exp_t e;
        e = '0;
        e.stall = 1'b1;
        e.busy  = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_redir(input logic [31:0] pc);
        exp_t e;
        e = '0;
        e.rv   = 1'b1;
        e.rpc  = pc;
        e.busy = 1'b1;
        return e;
    endfunction

    function automatic exp_t actual();
        exp_t a;
        a.flush = bus.flush;
        a.stall = bus.fetch_stall;
        a.rv    = bus.redirect_valid;
        a.rpc   = bus.redirect_pc;
        a.busy  = bus.ctrl_busy;
        return a;
    endfunction

    // One clock of stimulus plus the outputs expected during that clock.
    task automatic drive(input logic exc, input logic eret, input logic mtc0,
                         input logic jv, input logic [31:0] pc, input logic mb,
                         input exp_t e);
        @(posedge clk);
        #1;
        bus.exception_valid = exc;
        bus.eret_exist      = eret;
        bus.mtc0_exist      = mtc0;
        bus.jmp_valid       = jv;
        bus.jmp_pc          = pc;
        bus.mem_busy        = mb;
        exp_q.push_back(e);
    endtask

    // Random events while the pipeline is being killed; all must be ignored.
    task automatic drive_junk(input exp_t e, input logic mb);
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), JUNK_PC, mb, e);
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, $urandom, 1'($urandom_range(0, 1)), e_idle());
    endtask

    // kind bits: [0]=exception_valid [1]=eret_exist [2]=jmp_valid (non-zero).
    // b = cycles mem_busy stays high starting at the event cycle.
    task automatic do_redirect(input exp_t ev_out, input logic [2:0] kind, input int b,
                               input logic mtc0, input logic [31:0] pc);
        logic [31:0] tgt;
        tgt = kind[2] ? pc : EXC_VEC;
        drive(kind[0], kind[1], mtc0, kind[2], pc, b > 0, ev_out);
        for (int k = 1; k <= b; k++) drive_junk(e_flush(), k < b);
        for (int k = 0; k < FLUSH_CYCLES; k++) drive_junk(e_flush(), 1'($urandom_range(0, 1)));
        drive_junk(e_redir(tgt), 1'($urandom_range(0, 1)));
    endtask

    // MTC0 alone; if pre_at is 1..MTC0_HAZ a redirect arrives in that hazard cycle.
    task automatic do_mtc0(input int pre_at, input logic [2:0] kind, input int b,
                           input logic [31:0] pc);
        drive(1'b0, 1'b0, 1'b1, 1'b0, $urandom, 1'($urandom_range(0, 1)), e_idle());
        for (int h = 1; h <= MTC0_HAZ; h++) begin
            if (h == pre_at) begin
                do_redirect(e_haz(), kind, b, 1'($urandom_range(0, 1)), pc);
                return;
            end
            drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, $urandom,
                  1'($urandom_range(0, 1)), e_haz());
        end
    endtask

    // Scoreboard monitor: one expected entry per clock while enabled.
    initial begin : monitor
        exp_t e;
        exp_t a;
        int unsigned exp_redir;
        int unsigned exp_stall;
        exp_redir = 0;
        exp_stall = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow t=%0t actual=no entry required=entry", $time);
                end else begin
                    e = exp_q.pop_front();
                    a = actual();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL cycle_outputs t=%0t actual flush=%h stall=%b rv=%b rpc=%h busy=%b required flush=%h stall=%b rv=%b rpc=%h busy=%b",
                                 $time, a.flush, a.stall, a.rv, a.rpc, a.busy,
                                 e.flush, e.stall, e.rv, e.rpc, e.busy);
                    end
`ifdef WRITE_FLUSH_PERF_EN
                    checks++;
                    if (perf_redir_cnt !== exp_redir || perf_stall_cnt !== exp_stall) begin
                        errors++;
                        $display("FAIL perf_counts t=%0t actual redir=%0d stall=%0d required redir=%0d stall=%0d",
                                 $time, perf_redir_cnt, perf_stall_cnt, exp_redir, exp_stall);
                    end
                    exp_redir += e.rv;
                    exp_stall += e.stall;
`endif
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    initial begin : stimulus
        logic [2:0] kind;
        int         r;
        bus.exception_valid = 1'b0;
        bus.eret_exist      = 1'b0;
        bus.mtc0_exist      = 1'b0;
        bus.jmp_valid       = 1'b0;
        bus.jmp_pc          = '0;
        bus.mem_busy        = 1'b0;

        // Reset state, before any clock edge.
        #3;
        chk("reset_outputs", 64'(actual()), 64'(e_idle()));
`ifdef WRITE_FLUSH_PERF_EN
        chk("reset_perf", {perf_redir_cnt, perf_stall_cnt}, 64'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        mon_en = 1'b1;

        // Directed scenarios.
        do_redirect(e_idle(), 3'b100, 0, 1'b0, 32'h8000_1000);
        do_redirect(e_idle(), 3'b001, 4, 1'b0, 32'h0000_0000);
        do_mtc0(0, 3'b000, 0, 32'h0);
        do_mtc0(2, 3'b110, 0, 32'h8000_0200);
        do_redirect(e_idle(), 3'b100, 0, 1'b1, 32'h8000_0400);
        do_mtc0(MTC0_HAZ, 3'b001, 2, 32'h0);
        drive_idle();

        // Randomized transactions.
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 9);
            kind = 3'($urandom_range(1, 7));
            if (r <= 4) begin
                do_redirect(e_idle(), kind, $urandom_range(0, 4),
                            1'($urandom_range(0, 1)), $urandom);
            end else if (r <= 6) begin
                do_mtc0(0, kind, 0, 32'h0);
            end else if (r <= 8) begin
                do_mtc0($urandom_range(1, MTC0_HAZ), kind, $urandom_range(0, 3), $urandom);
            end else begin
                drive_idle();
            end
            repeat ($urandom_range(0, 1)) drive_idle();
        end
        drive_idle();
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset in the middle of a flush sequence.
        @(posedge clk);
        #1;
        bus.jmp_valid = 1'b1;
        bus.jmp_pc    = 32'h8000_1000;
        bus.mem_busy  = 1'b0;
        @(posedge clk);
        #1;
        bus.jmp_pc          = JUNK_PC;
        bus.exception_valid = 1'b1;
        #1;
        chk("pre_reset_flush", 64'(actual()), 64'(e_flush()));
        #1;
        resetn = 1'b0;
        #1;
        chk("async_reset", 64'(actual()), 64'(e_idle()));
`ifdef WRITE_FLUSH_PERF_EN
        chk("async_reset_perf", {perf_redir_cnt, perf_stall_cnt}, 64'd0);
`endif
        @(posedge clk);
        #1;
        chk("reset_hold", 64'(actual()), 64'(e_idle()));
        @(negedge clk);
        bus.jmp_valid       = 1'b0;
        bus.exception_valid = 1'b0;
        resetn              = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("post_reset_idle", 64'(actual()), 64'(e_idle()));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin : watchdog
        #500000;
        $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
